// File: rtl/button_event_pkg.sv
// -----------------------------------------------------------------------------
// button_event_pkg
// Shared types and helpers for the push-button event decoder.
//   state_e            : gesture state machine encoding
//   clogb2()           : number of bits needed to hold a non-negative value
//   max3()             : largest of three integers (counter sizing)
//   MIN_* constants    : smallest legal values of the decoder parameters
// -----------------------------------------------------------------------------
package button_event_pkg;

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    PRESSED     = 3'd1,
    LONG_HELD   = 3'd2,
    WAIT_GAP    = 3'd3,
    SECOND_HELD = 3'd4
  } state_e;

  localparam int MIN_LONG_COUNT   = 2;
  localparam int MIN_DOUBLE_GAP   = 1;
  localparam int MIN_REPEAT_COUNT = 1;

  // Bits required to represent 'value' (never less than 1).
  function automatic int clogb2(input int value);
    int v;
    int w;
    v = value;
    w = 0;
    while (v > 0) begin
      w = w + 1;
      v = v >>> 1;
    end
    if (w < 1) w = 1;
    return w;
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage

// File: rtl/button_tick_timer.sv
// -----------------------------------------------------------------------------
// button_tick_timer
// Tick-gated duration counter used by the button event decoder.
// All updates happen only when ce_i is high.
//   clk_i      : clock
//   rst_i      : asynchronous active-high reset (count -> 0)
//   ce_i       : tick enable
//   clr_i      : synchronous clear; combined with inc_i it loads 1
//   inc_i      : increment (ignored-as-add when clr_i is set)
//   term_i     : terminal value to compare against
//   at_term_o  : count equals term_i (combinational compare of the register)
// -----------------------------------------------------------------------------
module button_tick_timer #(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             ce_i,
  input  logic             clr_i,
  input  logic             inc_i,
  input  logic [WIDTH-1:0] term_i,
  output logic             at_term_o
);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (ce_i) begin
      if (clr_i) begin
        // clear+inc means "this tick is the first one counted"
        cnt_d = inc_i ? WIDTH'(1) : '0;
      end else if (inc_i) begin
        cnt_d = cnt_q + WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign at_term_o = (cnt_q == term_i);

endmodule

// File: rtl/button_event_decoder.sv
// -----------------------------------------------------------------------------
// button_event_decoder
// Turns a debounced button level into one-cycle short / long / double press
// pulses, with an optional auto-repeat stream while a long press is held.
// Durations are counted in ticks (aclk edges with ce_n low).
//
// Build option: define BUTTON_AUTOREPEAT_EN to enable repeat_press generation;
// without it repeat_press is tied low and no repeat logic exists.
//
// Ports:
//   aclk         : clock
//   areset       : asynchronous active-high reset
//   ce_n         : active-low tick enable (shared with the debouncer)
//   clean_pb     : debounced button level, 1 = pressed
//   short_press  : one-cycle pulse, single short press
//   long_press   : one-cycle pulse, press held LONG_COUNT ticks
//   double_press : one-cycle pulse, second press within DOUBLE_GAP ticks
//   repeat_press : one-cycle pulse every REPEAT_COUNT ticks while long-held
//   busy         : high whenever a gesture is in progress
// -----------------------------------------------------------------------------
module button_event_decoder
  import button_event_pkg::*;
#(
  parameter int LONG_COUNT   = 1000,
  parameter int DOUBLE_GAP   = 300,
  parameter int REPEAT_COUNT = 100
) (
  input  logic aclk,
  input  logic areset,
  input  logic ce_n,
  input  logic clean_pb,
  output logic short_press,
  output logic long_press,
  output logic double_press,
  output logic repeat_press,
  output logic busy
);

  localparam int CNT_W = clogb2(max3(LONG_COUNT, DOUBLE_GAP, REPEAT_COUNT));
  localparam logic [CNT_W-1:0] LONG_TERM = CNT_W'(LONG_COUNT - 1);
  localparam logic [CNT_W-1:0] GAP_TERM  = CNT_W'(DOUBLE_GAP);
`ifdef BUTTON_AUTOREPEAT_EN
  localparam logic [CNT_W-1:0] REP_TERM  = CNT_W'(REPEAT_COUNT - 1);
`endif

  state_e           state_q, state_d;
  logic             short_q, short_d;
  logic             long_q, long_d;
  logic             double_q, double_d;
  logic             busy_q;
  logic             tick;
  logic             cnt_clr, cnt_inc;
  logic [CNT_W-1:0] cnt_term;
  logic             at_term;

  assign tick = ~ce_n;

  button_tick_timer #(
    .WIDTH (CNT_W)
  ) u_timer (
    .clk_i     (aclk),
    .rst_i     (areset),
    .ce_i      (tick),
    .clr_i     (cnt_clr),
    .inc_i     (cnt_inc),
    .term_i    (cnt_term),
    .at_term_o (at_term)
  );

  // Terminal value depends only on the current state, so the compare is
  // ready before the tick that consumes it.
  always_comb begin
    cnt_term = '0;
    case (state_q)
      PRESSED:   cnt_term = LONG_TERM;
      WAIT_GAP:  cnt_term = GAP_TERM;
`ifdef BUTTON_AUTOREPEAT_EN
      LONG_HELD: cnt_term = REP_TERM;
`endif
      default:   cnt_term = '0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    cnt_clr  = 1'b0;
    cnt_inc  = 1'b0;
    short_d  = 1'b0;
    long_d   = 1'b0;
    double_d = 1'b0;
    if (tick) begin
      case (state_q)
        IDLE: begin
          if (clean_pb) begin
            state_d = PRESSED;
            cnt_clr = 1'b1;
            cnt_inc = 1'b1;
          end
        end
        PRESSED: begin
          // A release on the would-be long tick goes to WAIT_GAP: release wins.
          if (!clean_pb) begin
            state_d = WAIT_GAP;
            cnt_clr = 1'b1;
            cnt_inc = 1'b1;
          end else if (at_term) begin
            state_d = LONG_HELD;
            long_d  = 1'b1;
            cnt_clr = 1'b1;
          end else begin
            cnt_inc = 1'b1;
          end
        end
        LONG_HELD: begin
          if (!clean_pb) begin
            state_d = IDLE;
            cnt_clr = 1'b1;
          end
`ifdef BUTTON_AUTOREPEAT_EN
          else if (at_term) begin
            cnt_clr = 1'b1;
          end else begin
            cnt_inc = 1'b1;
          end
`endif
        end
        WAIT_GAP: begin
          // A re-press on the expiry tick still counts as double: re-press wins.
          if (clean_pb) begin
            state_d  = SECOND_HELD;
            double_d = 1'b1;
            cnt_clr  = 1'b1;
          end else if (at_term) begin
            state_d = IDLE;
            short_d = 1'b1;
            cnt_clr = 1'b1;
          end else begin
            cnt_inc = 1'b1;
          end
        end
        SECOND_HELD: begin
          if (!clean_pb) begin
            state_d = IDLE;
            cnt_clr = 1'b1;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_clr = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q  <= IDLE;
      short_q  <= 1'b0;
      long_q   <= 1'b0;
      double_q <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      short_q  <= short_d;
      long_q   <= long_d;
      double_q <= double_d;
      busy_q   <= (state_d != IDLE);
    end
  end

`ifdef BUTTON_AUTOREPEAT_EN
  logic repeat_q, repeat_d;

  // Wrap of the repeat counter while held is the repeat event.
  assign repeat_d = tick && (state_q == LONG_HELD) && clean_pb && at_term;

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) repeat_q <= 1'b0;
    else        repeat_q <= repeat_d;
  end

  assign repeat_press = repeat_q;
`else
  assign repeat_press = 1'b0;
`endif

  assign short_press  = short_q;
  assign long_press   = long_q;
  assign double_press = double_q;
  assign busy         = busy_q;

endmodule

// File: doc/button_event_decoder.md
# button_event_decoder

Classifies a debounced push-button level into discrete user events: short press, long press and double press, plus an optional auto-repeat stream while held. It sits directly downstream of the push-button debouncer, takes its `clean_pb` output, and shares the same `ce_n` tick so all durations are in debounce ticks. Its one-`aclk`-wide event pulses feed the front-panel/register logic that acts on button commands.

## Interface
Parameters:
- `LONG_COUNT`, default 1000: consecutive high ticks that make a long press; minimum 2.
- `DOUBLE_GAP`, default 300: maximum low ticks between a release and a second press that still counts as a double press; minimum 1.
- `REPEAT_COUNT`, default 100: ticks between auto-repeat pulses. Used only with `BUTTON_AUTOREPEAT_EN`; minimum 1.

Ports:
- `aclk`  in  1  clock.
- `areset`  in  1  asynchronous, active-high reset.
- `ce_n`  in  1  active-low tick enable; the same signal that drives the debouncer.
- `clean_pb`  in  1  debounced button level; 1 = pressed.
- `short_press`  out  1  one-`aclk` pulse.
- `long_press`  out  1  one-`aclk` pulse.
- `double_press`  out  1  one-`aclk` pulse.
- `repeat_press`  out  1  one-`aclk` pulse; tied 0 without the macro.
- `busy`  out  1  high whenever the state is not IDLE.

## Operation
- Tick: an `aclk` edge with `ce_n`=0.
- `clean_pb` is sampled, and state and counter update, on ticks only.
- Event pulses are registered:
  - high for exactly one `aclk` cycle, following the tick that qualifies the event;
  - cleared on the next `aclk` regardless of `ce_n`.
- State machine:
  - IDLE: sample 1 → PRESSED, cnt=1.
  - PRESSED:
    - Sample 1 with cnt==LONG_COUNT-1 → pulse `long_press`, go to LONG_HELD, cnt=0.
    - Otherwise sample 1 → cnt+1.
    - Sample 0 → WAIT_GAP, cnt=1.
  - LONG_HELD: sample 0 → IDLE, no further event.
  - WAIT_GAP:
    - Sample 1 → pulse `double_press`, go to SECOND_HELD.
    - Sample 0 with cnt==DOUBLE_GAP → pulse `short_press`, go to IDLE.
    - Otherwise sample 0 → cnt+1.
  - SECOND_HELD: sample 0 → IDLE. No long press is ever detected on a second press.
- Exactly one of short/long/double is pulsed per gesture.
- Counter:
  - Single shared counter, width `clogb2(max(LONG_COUNT, DOUBLE_GAP, REPEAT_COUNT))`.
  - Never exceeds its terminal value in any state.
- Boundaries:
  - Release sampled on the same tick that would reach LONG_COUNT: the release wins and gives WAIT_GAP, no long press.
  - Re-press sampled on the tick where cnt==DOUBLE_GAP would expire: the re-press wins and gives `double_press`.
  - Press of exactly LONG_COUNT-1 ticks: not long.
  - `areset` mid-gesture: immediate return to IDLE, cnt=0, all outputs 0. A button still held after reset release is treated as a new press.

## Timing
- Reset values: `short_press`=`long_press`=`double_press`=`repeat_press`=`busy`=0, state IDLE, cnt=0.
- Latency:
  - `long_press` is high on the `aclk` cycle after the LONG_COUNT-th consecutive high tick.
  - `short_press` is high on the cycle after the DOUBLE_GAP-th low tick following release.
  - `double_press` is high on the cycle after the first high tick in WAIT_GAP.
- `busy` is registered with the state. It rises the cycle after the first high tick and falls the cycle after the state returns to IDLE.
- With `ce_n` held high, state and counter freeze. Pending pulses still clear after one cycle.

## Configuration
- Macro: `BUTTON_AUTOREPEAT_EN`.
- Defined:
  - In LONG_HELD, each high tick increments cnt.
  - When cnt==REPEAT_COUNT-1, `repeat_press` pulses and cnt wraps to 0.
  - So the first repeat comes REPEAT_COUNT ticks after `long_press`, and repeats continue until release.
- Undefined: `repeat_press` is constant 0, no repeat logic is synthesised, and cnt stays 0 in LONG_HELD.

## Structure
- Package `button_event_pkg`:
  - state enum (IDLE, PRESSED, LONG_HELD, WAIT_GAP, SECOND_HELD);
  - `clogb2` function;
  - minimum-parameter constants.
- Sub-module `button_tick_timer`: ce-gated counter with synchronous clear, increment, terminal-compare input and async reset. The FSM instantiates it once.
- The debouncer is instantiated by the parent, not inside this block.

## Test plan
All scenarios use LONG_COUNT=4, DOUBLE_GAP=3, REPEAT_COUNT=2, and `ce_n` low every 4th `aclk`.
- Press 2 ticks, release → `short_press` single pulse after the 3rd low tick; no other pulses; `busy` then falls.
- Press 4 ticks → `long_press` pulse after tick 4. Release → no further pulse.
- Press 3 ticks, release 2 ticks, press 1 tick → `double_press` after the re-press tick; hold 10 more ticks gives no `long_press`.
- Release at the 4th high tick → no `long_press`; `short_press` after 3 low ticks.
- Assert `areset` while in WAIT_GAP and hold `clean_pb`=0 → all outputs 0, no `short_press` ever.
- Macro on, hold 10 ticks → `long_press` after tick 4; `repeat_press` pulses after ticks 6, 8 and 10. Macro off → `repeat_press` stays 0.
